// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one FIFO write port between two producers.
//   Grants are burst-locked. The current owner keeps the port for up to
//   2**BURST_W accepted words while the other requester is waiting. It then
//   hands over directly, with no idle cycle. The FIFO full flag stalls the
//   owner without releasing ownership.
//
// Parameters:
//   B        word width in bits (must match the FIFO)
//   BURST_W  burst counter width; maximum burst is 2**BURST_W words
//
// Ports:
//   clk       in   system clock, rising-edge active
//   reset     in   asynchronous, active-high reset
//   req0      in   requester 0 has a word; held until accepted
//   w_data0   in   requester 0 data, stable while req0=1 and not accepted
//   req1      in   requester 1 request
//   w_data1   in   requester 1 data
//   full      in   FIFO full flag
//   gnt0      out  requester 0 owns the write port (Moore)
//   gnt1      out  requester 1 owns the write port (Moore)
//   wr        out  FIFO write strobe (owner request and not full)
//   w_data    out  FIFO write data (owner's data, 0 when idle)
//   cnt0/cnt1 out  16-bit accepted-word counters. These ports exist only
//                  when FIFO_WR_ARB_STATS_EN is defined.
//
// Optional feature macro: FIFO_WR_ARB_STATS_EN
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int B       = 8,
    parameter int BURST_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [B-1:0] w_data0,
    input  logic         req1,
    input  logic [B-1:0] w_data1,
    input  logic         full,
    output logic         gnt0,
    output logic         gnt1,
    output logic         wr,
    output logic [B-1:0] w_data
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]  cnt0,
    output logic [15:0]  cnt1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [BURST_W-1:0] BCNT_MAX  = {BURST_W{1'b1}};
    localparam logic [BURST_W-1:0] BCNT_ZERO = {BURST_W{1'b0}};

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [BURST_W-1:0] bcnt_q, bcnt_d;

    // State, last-owner and burst-counter registers.
    // last resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            bcnt_q  <= BCNT_ZERO;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Next-state logic: idle arbitration, burst counting and handover.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            ST_IDLE: begin
                bcnt_d = BCNT_ZERO;
                if (req0 && req1) begin
                    // Tie: the requester that did not own the port last wins.
                    if (last_q) begin
                        state_d = ST_OWN0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = ST_OWN1;
                        last_d  = 1'b1;
                    end
                end else if (req0) begin
                    state_d = ST_OWN0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = ST_OWN1;
                    last_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    state_d = ST_IDLE;
                    bcnt_d  = BCNT_ZERO;
                end else if (wr) begin
                    if ((bcnt_q == BCNT_MAX) && req1) begin
                        state_d = ST_OWN1;
                        last_d  = 1'b1;
                        bcnt_d  = BCNT_ZERO;
                    end else begin
                        // At the maximum count with no waiter, the counter
                        // wraps to 0 and a new burst starts.
                        bcnt_d = bcnt_q + BURST_W'(1);
                    end
                end else begin
                    // FIFO full: hold ownership and count.
                    bcnt_d = bcnt_q;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    state_d = ST_IDLE;
                    bcnt_d  = BCNT_ZERO;
                end else if (wr) begin
                    if ((bcnt_q == BCNT_MAX) && req0) begin
                        state_d = ST_OWN0;
                        last_d  = 1'b0;
                        bcnt_d  = BCNT_ZERO;
                    end else begin
                        bcnt_d = bcnt_q + BURST_W'(1);
                    end
                end else begin
                    bcnt_d = bcnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                last_d  = 1'b1;
                bcnt_d  = BCNT_ZERO;
            end
        endcase
    end

    // Output decode: Moore grants plus a combinational write strobe and mux.
    // Because the outputs decode state_q, an asynchronous reset clears them
    // at once, without waiting for a clock edge.
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        wr     = 1'b0;
        w_data = {B{1'b0}};
        case (state_q)
            ST_IDLE: begin
                gnt0   = 1'b0;
                gnt1   = 1'b0;
            end
            ST_OWN0: begin
                gnt0   = 1'b1;
                wr     = req0 & ~full;
                w_data = w_data0;
            end
            ST_OWN1: begin
                gnt1   = 1'b1;
                wr     = req1 & ~full;
                w_data = w_data1;
            end
            default: begin
                gnt0   = 1'b0;
                gnt1   = 1'b0;
            end
        endcase
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // Accepted-word counters. They wrap naturally at 2**16.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (wr && (state_q == ST_OWN0)) begin
            cnt0_d = cnt0_q + 16'd1;
        end else begin
            cnt0_d = cnt0_q;
        end
        if (wr && (state_q == ST_OWN1)) begin
            cnt1_d = cnt1_q + 16'd1;
        end else begin
            cnt1_d = cnt1_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for fifo_wr_arbiter (B=8, BURST_W=2).
// Each requester is a word queue: req is high while its queue is non-empty,
// and the head word is popped after an edge at which it was accepted.
// Expected writes ({source, data}) are pushed to a scoreboard up front and
// popped whenever the DUT strobes wr.
module tb_fifo_wr_arbiter;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, full = 1'b0;
    logic [7:0] w_data0 = 8'h00, w_data1 = 8'h00;
    logic       gnt0, gnt1, wr;
    logic [7:0] w_data;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] cnt0, cnt1;
`endif

    logic [7:0] src0_q[$];
    logic [7:0] src1_q[$];
    logic [8:0] exp_q[$];
    int n_pass = 0;
    int n_total = 0;

    fifo_wr_arbiter #(.B(8), .BURST_W(2)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .w_data0(w_data0),
        .req1(req1), .w_data1(w_data1),
        .full(full),
        .gnt0(gnt0), .gnt1(gnt1), .wr(wr), .w_data(w_data)
`ifdef FIFO_WR_ARB_STATS_EN
        , .cnt0(cnt0), .cnt1(cnt1)
`endif
    );

    always #(T/2) clk = ~clk;

    task automatic update_reqs();
        req0    = (src0_q.size() != 0);
        w_data0 = req0 ? src0_q[0] : 8'h00;
        req1    = (src1_q.size() != 0);
        w_data1 = req1 ? src1_q[0] : 8'h00;
    endtask

    task automatic load0(input logic [7:0] d);
        src0_q.push_back(d);
        update_reqs();
    endtask

    task automatic load1(input logic [7:0] d);
        src1_q.push_back(d);
        update_reqs();
    endtask

    // Sample the outputs on the falling edge, then let the requesters react
    // to the acceptance just after the rising edge.
    task automatic drive_cycle(output logic g0, output logic g1, output logic w,
                               output logic [7:0] d);
        logic a0, a1;
        @(negedge clk);
        g0 = gnt0; g1 = gnt1; w = wr; d = w_data;
        a0 = gnt0 & req0 & ~full;
        a1 = gnt1 & req1 & ~full;
        @(posedge clk);
        #1;
        if (a0) void'(src0_q.pop_front());
        if (a1) void'(src1_q.pop_front());
        update_reqs();
    endtask

    // Hold reset for two edges, release it, and finish just after a rising edge.
    task automatic apply_reset();
        reset = 1'b1;
        full  = 1'b0;
        src0_q.delete();
        src1_q.delete();
        exp_q.delete();
        update_reqs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load0(8'hAA);
        load1(8'h55);
        #1;
        n_total++; if (gnt0 !== 1'b0) $display("FAIL rst_gnt0 got %b want 0", gnt0); else n_pass++;
        n_total++; if (gnt1 !== 1'b0) $display("FAIL rst_gnt1 got %b want 0", gnt1); else n_pass++;
        n_total++; if (wr !== 1'b0) $display("FAIL rst_wr got %b want 0", wr); else n_pass++;
        n_total++; if (w_data !== 8'h00) $display("FAIL rst_wdata got %h want 00", w_data); else n_pass++;
`ifdef FIFO_WR_ARB_STATS_EN
        n_total++; if (cnt0 !== 16'd0) $display("FAIL rst_cnt0 got %0d want 0", cnt0); else n_pass++;
        n_total++; if (cnt1 !== 16'd0) $display("FAIL rst_cnt1 got %0d want 0", cnt1); else n_pass++;
`endif
        apply_reset();
    endtask

    task automatic test_single();
        logic g0, g1, w;
        logic [7:0] d;
        logic [8:0] e;
        apply_reset();
        for (int i = 4; i >= 0; i--) begin
            load0(8'(i));
            exp_q.push_back({1'b0, 8'(i)});
        end
        for (int k = 0; k < 8; k++) begin
            drive_cycle(g0, g1, w, d);
            n_total++; if (g1 !== 1'b0) $display("FAIL t1_gnt1_k%0d got %b want 0", k, g1); else n_pass++;
            if (k == 0) begin
                n_total++; if (g0 !== 1'b0) $display("FAIL t1_gnt0_latency got %b want 0", g0); else n_pass++;
            end
            if (k >= 1 && k <= 5) begin
                n_total++; if (g0 !== 1'b1) $display("FAIL t1_gnt0_k%0d got %b want 1", k, g0); else n_pass++;
                n_total++; if (w !== 1'b1) $display("FAIL t1_wr_k%0d got %b want 1", k, w); else n_pass++;
            end
            if (w) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL t1_extra_write got %h want none", d);
                else begin
                    e = exp_q.pop_front();
                    if ({g1, d} !== e) $display("FAIL t1_data got %h want %h", {g1, d}, e); else n_pass++;
                end
            end
        end
        n_total++; if (exp_q.size() != 0) $display("FAIL t1_missing got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_contention();
        logic g0, g1, w;
        logic [7:0] d;
        logic [8:0] e;
        int both;
        both = 0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            load0(8'h10 + 8'(i));
            load1(8'h20 + 8'(i));
        end
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 4; i++)
                exp_q.push_back({1'(b % 2), ((b % 2) != 0 ? 8'h20 : 8'h10) + 8'((b / 2) * 4 + i)});
        for (int k = 0; k < 19; k++) begin
            drive_cycle(g0, g1, w, d);
            if (g0 && g1) both++;
            if (k == 0) begin
                n_total++; if ({g0, g1} !== 2'b00) $display("FAIL t2_idle got %b want 00", {g0, g1}); else n_pass++;
            end
            if (k == 1) begin
                n_total++; if (g0 !== 1'b1) $display("FAIL t2_first_gnt0 got %b want 1", g0); else n_pass++;
            end
            if (k >= 1 && k <= 16) begin
                n_total++; if (w !== 1'b1) $display("FAIL t2_gap_k%0d got wr=%b want 1", k, w); else n_pass++;
            end
            if (w) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL t2_extra_write got %h want none", d);
                else begin
                    e = exp_q.pop_front();
                    if ({g1, d} !== e) $display("FAIL t2_data_k%0d got %h want %h", k, {g1, d}, e); else n_pass++;
                end
            end
        end
        n_total++; if (both != 0) $display("FAIL t2_mutex got %0d want 0", both); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL t2_missing got %0d want 0", exp_q.size()); else n_pass++;
`ifdef FIFO_WR_ARB_STATS_EN
        n_total++; if (cnt0 !== 16'd8) $display("FAIL t6_cnt0 got %0d want 8", cnt0); else n_pass++;
        n_total++; if (cnt1 !== 16'd8) $display("FAIL t6_cnt1 got %0d want 8", cnt1); else n_pass++;
`endif
    endtask

    task automatic test_full_stall();
        logic g0, g1, w;
        logic [7:0] d;
        logic [8:0] e;
        apply_reset();
        for (int i = 0; i < 6; i++) load0(8'h30 + 8'(i));
        load1(8'h40);
        load1(8'h41);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h30 + 8'(i)});
        exp_q.push_back({1'b1, 8'h40});
        exp_q.push_back({1'b1, 8'h41});
        exp_q.push_back({1'b0, 8'h34});
        exp_q.push_back({1'b0, 8'h35});
        for (int k = 0; k < 16; k++) begin
            full = (k >= 3 && k <= 5);
            drive_cycle(g0, g1, w, d);
            if (k >= 3 && k <= 5) begin
                n_total++; if (w !== 1'b0) $display("FAIL t3_stall_wr_k%0d got %b want 0", k, w); else n_pass++;
                n_total++; if (g0 !== 1'b1) $display("FAIL t3_stall_gnt0_k%0d got %b want 1", k, g0); else n_pass++;
                n_total++; if (dut.bcnt_q !== 2'd2) $display("FAIL t3_bcnt_k%0d got %0d want 2", k, dut.bcnt_q); else n_pass++;
            end
            if (k == 8) begin
                n_total++; if (g1 !== 1'b1) $display("FAIL t3_handover got %b want 1", g1); else n_pass++;
            end
            if (w) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL t3_extra_write got %h want none", d);
                else begin
                    e = exp_q.pop_front();
                    if ({g1, d} !== e) $display("FAIL t3_data_k%0d got %h want %h", k, {g1, d}, e); else n_pass++;
                end
            end
        end
        full = 1'b0;
        n_total++; if (exp_q.size() != 0) $display("FAIL t3_missing got %0d want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_early_release();
        logic g0, g1, w;
        logic [7:0] d;
        logic [8:0] e;
        apply_reset();
        load1(8'h50);
        exp_q.push_back({1'b1, 8'h50});
        exp_q.push_back({1'b0, 8'h60});
        for (int k = 0; k < 6; k++) begin
            drive_cycle(g0, g1, w, d);
            if (k == 0) load0(8'h60);
            if (k == 2) begin
                n_total++; if (w !== 1'b0) $display("FAIL t4_drop_wr got %b want 0", w); else n_pass++;
            end
            if (k == 3) begin
                n_total++; if ({g0, g1, w} !== 3'b000) $display("FAIL t4_idle got %b want 000", {g0, g1, w}); else n_pass++;
            end
            if (k == 4) begin
                n_total++; if (g0 !== 1'b1) $display("FAIL t4_gnt0 got %b want 1", g0); else n_pass++;
            end
            if (w) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL t4_extra_write got %h want none", d);
                else begin
                    e = exp_q.pop_front();
                    if ({g1, d} !== e) $display("FAIL t4_data_k%0d got %h want %h", k, {g1, d}, e); else n_pass++;
                end
            end
        end
        n_total++; if (exp_q.size() != 0) $display("FAIL t4_missing got %0d want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_async_reset();
        logic g0, g1, w;
        logic [7:0] d;
        apply_reset();
        load1(8'h70);
        load1(8'h71);
        drive_cycle(g0, g1, w, d);
        @(negedge clk);
        n_total++; if ({gnt1, wr} !== 2'b11) $display("FAIL t5_pre got %b want 11", {gnt1, wr}); else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_total++; if (gnt1 !== 1'b0) $display("FAIL t5_gnt1 got %b want 0", gnt1); else n_pass++;
        n_total++; if (wr !== 1'b0) $display("FAIL t5_wr got %b want 0", wr); else n_pass++;
        n_total++; if (w_data !== 8'h00) $display("FAIL t5_wdata got %h want 00", w_data); else n_pass++;
`ifdef FIFO_WR_ARB_STATS_EN
        n_total++; if (cnt1 !== 16'd0) $display("FAIL t6_rst_cnt1 got %0d want 0", cnt1); else n_pass++;
`endif
        #1 reset = 1'b0;
        load0(8'h80);
        @(posedge clk);
        #1;
        drive_cycle(g0, g1, w, d);
        n_total++; if ({g0, g1} !== 2'b10) $display("FAIL t5_first_gnt got %b want 10", {g0, g1}); else n_pass++;
        n_total++; if ({w, d} !== {1'b1, 8'h80}) $display("FAIL t5_write got %h want 180", {w, d}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full_stall();
        test_early_release();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
